// File: rtl/lin_tx_buffer.sv
// LIN transmit frame buffer: 32-bit word FIFO feeding a byte-serial valid/ready stream.
// Optional macro LIN_TX_CHECKSUM_EN appends the LIN classic checksum byte to each frame.
module lin_tx_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [31:0]   wr_data,
    output logic          full,
    output logic [AW:0]   level,
    input  logic          start,
    input  logic [3:0]    len,
    output logic          busy,
    output logic          len_err,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [7:0]    tx_byte,
    output logic          tx_last,
    output logic          frame_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        DONE  = 3'd3
`ifdef LIN_TX_CHECKSUM_EN
        ,CSUM = 3'd4
`endif
    } state_t;

    state_t state, state_next;

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [31:0] word;
    logic [3:0]  len_q;
    logic [3:0]  byte_cnt;
    logic [1:0]  idx;

    logic push, pop, len_ok, data_hs, last_data;

    assign level     = wr_ptr - rd_ptr;
    assign full      = (level == (AW+1)'(DEPTH));
    assign push      = wr_en && !full && !flush;
    assign pop       = (state == FETCH) && (level != '0) && !flush;
    assign len_ok    = (len != 4'd0) && (len <= 4'd8);
    assign data_hs   = (state == SEND) && tx_ready;
    assign last_data = ((byte_cnt + 4'd1) == len_q);

`ifdef LIN_TX_CHECKSUM_EN
    logic [7:0] sum, sum_next;
    logic [8:0] acc;
    // Running one's-complement style sum with end-around carry
    always_comb begin
        acc      = {1'b0, sum} + {1'b0, tx_byte};
        sum_next = acc[7:0] + {7'd0, acc[8]};
    end
`endif

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Pointers, shift word, frame counters and sticky length error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word     <= '0;
            len_q    <= '0;
            byte_cnt <= '0;
            idx      <= '0;
            len_err  <= 1'b0;
`ifdef LIN_TX_CHECKSUM_EN
            sum      <= '0;
`endif
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            len_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                word   <= mem[rd_ptr[AW-1:0]];
                idx    <= '0;
            end
            if (state == IDLE && start) begin
                if (len_ok) begin
                    len_q    <= len;
                    byte_cnt <= '0;
                    idx      <= '0;
`ifdef LIN_TX_CHECKSUM_EN
                    sum      <= '0;
`endif
                end else begin
                    len_err <= 1'b1;
                end
            end
            if (data_hs) begin
                byte_cnt <= byte_cnt + 4'd1;
                if (!last_data && idx != 2'd3) idx <= idx + 2'd1;
`ifdef LIN_TX_CHECKSUM_EN
                sum <= sum_next;
`endif
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start && len_ok) state_next = FETCH;
            FETCH: if (level != '0) state_next = SEND;
            SEND: begin
                if (data_hs) begin
                    if (last_data)
`ifdef LIN_TX_CHECKSUM_EN
                        state_next = CSUM;
`else
                        state_next = DONE;
`endif
                    else if (idx == 2'd3)
                        state_next = FETCH;
                end
            end
`ifdef LIN_TX_CHECKSUM_EN
            CSUM:  if (tx_ready) state_next = DONE;
`endif
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Outputs decoded from state
    always_comb begin
        busy       = (state != IDLE);
        tx_valid   = 1'b0;
        tx_byte    = 8'h00;
        tx_last    = 1'b0;
        frame_done = (state == DONE);
        case (state)
            SEND: begin
                tx_valid = 1'b1;
                tx_byte  = word[{idx, 3'b000} +: 8];
`ifndef LIN_TX_CHECKSUM_EN
                tx_last  = last_data;
`endif
            end
`ifdef LIN_TX_CHECKSUM_EN
            CSUM: begin
                tx_valid = 1'b1;
                tx_byte  = ~sum;
                tx_last  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lin_tx_buffer.sv
// Directed testbench for lin_tx_buffer.
// Expected per-cycle vectors are hand-computed from the frame timing.
module tb_lin_tx_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [31:0]   wr_data = '0;
    logic          full;
    logic [AW:0]   level;
    logic          start = 1'b0;
    logic [3:0]    len = '0;
    logic          busy;
    logic          len_err;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [7:0]    tx_byte;
    logic          tx_last;
    logic          frame_done;

    int vectors = 0;
    int miscompares = 0;

    // {busy, tx_valid, masked tx_byte, tx_last, frame_done}
    logic [11:0] obs;
    assign obs = {busy, tx_valid, (tx_valid ? tx_byte : 8'h00), tx_last, frame_done};

    always #5 clk = ~clk;

    lin_tx_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .level(level),
        .start(start), .len(len), .busy(busy), .len_err(len_err),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte),
        .tx_last(tx_last), .frame_done(frame_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [16:0] got;
        tick;
        tick;
        got = {full, level, busy, len_err, tx_valid, tx_byte, tx_last, frame_done};
        vectors++;
        if (got !== 17'd0) begin
            miscompares++;
            $display("FAIL reset got %h exp %h", got, 17'd0);
        end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_frame8;
        logic [11:0] exp [1:12];
        exp[1]  = 12'h800;
        exp[2]  = {2'b11, 8'h11, 2'b00};
        exp[3]  = {2'b11, 8'h22, 2'b00};
        exp[4]  = {2'b11, 8'h33, 2'b00};
        exp[5]  = {2'b11, 8'h44, 2'b00};
        exp[6]  = 12'h800;
        exp[7]  = {2'b11, 8'h55, 2'b00};
        exp[8]  = {2'b11, 8'h66, 2'b00};
        exp[9]  = {2'b11, 8'h77, 2'b00};
        exp[10] = {2'b11, 8'h88, 2'b10};
        exp[11] = 12'h801;
        exp[12] = 12'h000;
        wr_en = 1'b1;
        wr_data = 32'h44332211;
        tick;
        wr_data = 32'h88776655;
        tick;
        wr_en = 1'b0;
        vectors++;
        if (level !== 3'd2) begin
            miscompares++;
            $display("FAIL frame8_level got %0d exp 2", level);
        end
        tx_ready = 1'b1;
        start = 1'b1;
        len = 4'd8;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            vectors++;
            if (obs !== exp[k]) begin
                miscompares++;
                $display("FAIL frame8 k=%0d got %h exp %h", k, obs, exp[k]);
            end
            // illegal start while busy must be ignored
            start = (k == 3);
            len = 4'd0;
            tick;
        end
        start = 1'b0;
        vectors++;
        if ({level, len_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL frame8_end level=%0d len_err=%b exp 0 0", level, len_err);
        end
    endtask

    task automatic test_stall;
        logic [11:0] exp [1:9];
        logic        rdy [1:9];
        exp[1] = 12'h800;                   rdy[1] = 1'b0;
        exp[2] = {2'b11, 8'hAA, 2'b00};     rdy[2] = 1'b0;
        exp[3] = {2'b11, 8'hAA, 2'b00};     rdy[3] = 1'b1;
        exp[4] = {2'b11, 8'hBB, 2'b00};     rdy[4] = 1'b0;
        exp[5] = {2'b11, 8'hBB, 2'b00};     rdy[5] = 1'b1;
        exp[6] = {2'b11, 8'hCC, 2'b10};     rdy[6] = 1'b0;
        exp[7] = {2'b11, 8'hCC, 2'b10};     rdy[7] = 1'b1;
        exp[8] = 12'h801;                   rdy[8] = 1'b0;
        exp[9] = 12'h000;                   rdy[9] = 1'b0;
        tx_ready = 1'b0;
        wr_en = 1'b1;
        wr_data = 32'hDDCCBBAA;
        tick;
        wr_en = 1'b0;
        start = 1'b1;
        len = 4'd3;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            vectors++;
            if (obs !== exp[k]) begin
                miscompares++;
                $display("FAIL stall k=%0d got %h exp %h", k, obs, exp[k]);
            end
            tx_ready = rdy[k];
            tick;
        end
        vectors++;
        if (level !== 3'd0) begin
            miscompares++;
            $display("FAIL stall_level got %0d exp 0", level);
        end
    endtask

    task automatic test_full;
        logic [15:0] exp [1:7];
        exp[1] = {12'h800, 1'b1, 3'd4};
        exp[2] = {2'b11, 8'hD0, 2'b00, 1'b0, 3'd3};
        exp[3] = {2'b11, 8'hC0, 2'b00, 1'b0, 3'd3};
        exp[4] = {2'b11, 8'hB0, 2'b00, 1'b0, 3'd3};
        exp[5] = {2'b11, 8'hA0, 2'b10, 1'b0, 3'd3};
        exp[6] = {12'h801, 1'b0, 3'd3};
        exp[7] = {12'h000, 1'b0, 3'd3};
        wr_en = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            wr_data = 32'hA0B0C0D0 + 32'(i);
            tick;
        end
        wr_en = 1'b0;
        vectors++;
        if ({full, level} !== {1'b1, 3'd4}) begin
            miscompares++;
            $display("FAIL full_flag full=%b level=%0d exp 1 4", full, level);
        end
        tx_ready = 1'b1;
        start = 1'b1;
        len = 4'd4;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            vectors++;
            if ({obs, full, level} !== exp[k]) begin
                miscompares++;
                $display("FAIL full_pop k=%0d got %h exp %h", k, {obs, full, level}, exp[k]);
            end
            // push at full concurrent with the FETCH pop must be dropped
            wr_en = (k == 1);
            wr_data = 32'hDEADBEEF;
            tick;
        end
        wr_en = 1'b0;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        vectors++;
        if ({full, level} !== 4'b0000) begin
            miscompares++;
            $display("FAIL full_flush full=%b level=%0d exp 0 0", full, level);
        end
    endtask

    task automatic test_len_err;
        start = 1'b1;
        len = 4'd0;
        tick;
        start = 1'b0;
        tick;
        vectors++;
        if ({len_err, busy, tx_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL len0 got %b exp 100", {len_err, busy, tx_valid});
        end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        vectors++;
        if (len_err !== 1'b0) begin
            miscompares++;
            $display("FAIL len_err_flush got %b exp 0", len_err);
        end
        start = 1'b1;
        len = 4'd9;
        tick;
        start = 1'b0;
        tick;
        vectors++;
        if ({len_err, busy, tx_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL len9 got %b exp 100", {len_err, busy, tx_valid});
        end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        vectors++;
        if (len_err !== 1'b0) begin
            miscompares++;
            $display("FAIL len_err_clear got %b exp 0", len_err);
        end
    endtask

    task automatic test_empty_wait;
        tx_ready = 1'b0;
        start = 1'b1;
        len = 4'd1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (obs !== 12'h800) begin
                miscompares++;
                $display("FAIL wait i=%0d got %h exp 800", i, obs);
            end
            tick;
        end
        wr_en = 1'b1;
        wr_data = 32'h00000001;
        tick;
        wr_en = 1'b0;
        vectors++;
        if (obs !== 12'h800) begin
            miscompares++;
            $display("FAIL wait_push got %h exp 800", obs);
        end
        tick;
        vectors++;
        if (obs !== {2'b11, 8'h01, 2'b10}) begin
            miscompares++;
            $display("FAIL wait_valid got %h exp %h", obs, {2'b11, 8'h01, 2'b10});
        end
        tx_ready = 1'b1;
        tick;
        tx_ready = 1'b0;
        vectors++;
        if (obs !== 12'h801) begin
            miscompares++;
            $display("FAIL wait_done got %h exp 801", obs);
        end
        tick;
        // second frame, aborted by flush while a byte is pending
        wr_en = 1'b1;
        wr_data = 32'h00000001;
        tick;
        wr_data = 32'h00000002;
        tick;
        wr_en = 1'b0;
        start = 1'b1;
        len = 4'd8;
        tick;
        start = 1'b0;
        tick;
        vectors++;
        if (obs !== {2'b11, 8'h01, 2'b00}) begin
            miscompares++;
            $display("FAIL abort_send got %h exp %h", obs, {2'b11, 8'h01, 2'b00});
        end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        vectors++;
        if ({obs, level} !== 15'd0) begin
            miscompares++;
            $display("FAIL abort_flush got %h exp 0", {obs, level});
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            vectors++;
            if (obs !== 12'h000) begin
                miscompares++;
                $display("FAIL abort_idle i=%0d got %h exp 000", i, obs);
            end
        end
    endtask

    task automatic test_multiword;
`ifdef LIN_TX_CHECKSUM_EN
        localparam int N = 10;
        logic [7:0] data [5];
        logic [8:0] acc;
        logic [7:0] s;
        logic [7:0] cs;
`else
        localparam int N = 9;
`endif
        logic [11:0] exp [1:N];
        exp[1] = 12'h800;
        exp[2] = {2'b11, 8'hFF, 2'b00};
        exp[3] = {2'b11, 8'h00, 2'b00};
        exp[4] = {2'b11, 8'h00, 2'b00};
        exp[5] = {2'b11, 8'h00, 2'b00};
        exp[6] = 12'h800;
`ifdef LIN_TX_CHECKSUM_EN
        data[0] = 8'hFF;
        data[1] = 8'h00;
        data[2] = 8'h00;
        data[3] = 8'h00;
        data[4] = 8'h02;
        s = 8'h00;
        for (int i = 0; i < 5; i++) begin
            acc = {1'b0, s} + {1'b0, data[i]};
            s = acc[7:0] + {7'd0, acc[8]};
        end
        cs = ~s;
        exp[7]  = {2'b11, 8'h02, 2'b00};
        exp[8]  = {2'b11, cs, 2'b10};
        exp[9]  = 12'h801;
        exp[10] = 12'h000;
`else
        exp[7] = {2'b11, 8'h02, 2'b10};
        exp[8] = 12'h801;
        exp[9] = 12'h000;
`endif
        wr_en = 1'b1;
        wr_data = 32'h000000FF;
        tick;
        wr_data = 32'h00000002;
        tick;
        wr_en = 1'b0;
        tx_ready = 1'b1;
        start = 1'b1;
        len = 4'd5;
        tick;
        start = 1'b0;
        for (int k = 1; k <= N; k++) begin
            vectors++;
            if (obs !== exp[k]) begin
                miscompares++;
                $display("FAIL multiword k=%0d got %h exp %h", k, obs, exp[k]);
            end
            tick;
        end
        tx_ready = 1'b0;
        vectors++;
        if (level !== 3'd0) begin
            miscompares++;
            $display("FAIL multiword_level got %0d exp 0", level);
        end
    endtask

    initial begin
        test_reset;
        test_frame8;
        test_stall;
        test_full;
        test_len_err;
        test_empty_wait;
        test_multiword;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
